// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA display path: default 640x480@60 Hz timing
// constants (porches, sync widths, derived totals and active-area origins),
// RGB444 colour constants used by the pixel generator, the bundle of
// registered display-pin outputs, and a small range-compare helper.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;

  // Vertical timing, in lines
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;

  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 800
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 525

  // First counter value of the visible area
  localparam int HA0      = H_SYNC + H_BP;                    // 144
  localparam int VA0      = V_SYNC + V_BP;                    // 35

  // Both totals must stay within 1024 so the counters fit in 10 bits
  localparam int CNT_W    = 10;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t BLACK   = 12'h000;
  localparam rgb444_t WHITE   = 12'hFFF;
  localparam rgb444_t RED     = 12'hF00;
  localparam rgb444_t GREEN   = 12'h0F0;
  localparam rgb444_t BLUE    = 12'h00F;
  localparam rgb444_t YELLOW  = 12'hFF0;
  localparam rgb444_t CYAN    = 12'h0FF;
  localparam rgb444_t MAGENTA = 12'hF0F;
  localparam rgb444_t GRAY    = 12'h888;

  // Everything that leaves the block on the display side, one register stage
  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    de;
    logic    frame_start;
    rgb444_t rgb;
  } vga_out_t;

  // Idle pin state: syncs inactive (high), blanked, no frame pulse
  localparam vga_out_t VGA_OUT_IDLE = '{
    hsync:       1'b1,
    vsync:       1'b1,
    de:          1'b0,
    frame_start: 1'b0,
    rgb:         BLACK
  };

  // True when lo <= val < lo+len. Done in int so an end bound of 1024 is
  // still representable.
  function automatic logic in_span(input logic [CNT_W-1:0] val,
                                   input int lo, input int len);
    return (int'(val) >= lo) && (int'(val) < lo + len);
  endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// ---------------------------------------------------------------------------
// vga_hv_counter
// Horizontal/vertical scan position counters. cnt_h runs 0..H_TOT-1 and wraps;
// cnt_v advances on every cnt_h wrap and itself wraps after V_TOT-1, so the
// last pixel of the last line goes straight to (0,0) with no skipped or
// doubled line.
//
// Ports:
//   vga_clk  in   pixel clock, rising edge
//   rst_n    in   asynchronous active-low reset, counters to 0
//   cnt_h    out  10-bit column position (includes blanking)
//   cnt_v    out  10-bit line position (includes blanking)
// ---------------------------------------------------------------------------
module vga_hv_counter
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_v
);

  logic [CNT_W-1:0] cnt_h_reg, cnt_h_next;
  logic [CNT_W-1:0] cnt_v_reg, cnt_v_next;
  logic             h_last, v_last;

  always_comb begin
    h_last     = (cnt_h_reg == CNT_W'(H_TOT - 1));
    v_last     = (cnt_v_reg == CNT_W'(V_TOT - 1));
    cnt_h_next = h_last ? '0 : cnt_h_reg + 1'b1;
    cnt_v_next = cnt_v_reg;
    if (h_last) begin
      cnt_v_next = v_last ? '0 : cnt_v_reg + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_reg <= '0;
      cnt_v_reg <= '0;
    end else begin
      cnt_h_reg <= cnt_h_next;
      cnt_v_reg <= cnt_v_next;
    end
  end

  assign cnt_h = cnt_h_reg;
  assign cnt_v = cnt_v_reg;

endmodule

// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
// 640x480@60 Hz VGA timing generator and display-pin driver. Issues the next
// pixel coordinate to the colour generator one clock ahead of the visible
// area, takes the generator's registered colour back, and registers
// hsync/vsync/de/rgb/frame_start together so they stay mutually aligned.
//
// Ports:
//   vga_clk      in   pixel clock (25.175 MHz), rising edge
//   rst_n        in   asynchronous active-low reset
//   pix_data     in   RGB444 colour for the previously requested pixel
//   pix_x        out  requested column (0 outside the request window)
//   pix_y        out  requested row    (0 outside the request window)
//   hsync        out  horizontal sync, active-low, registered
//   vsync        out  vertical sync, active-low, registered
//   de           out  display enable, registered
//   rgb          out  colour to the DAC, black when not displaying
//   frame_start  out  one-clock pulse on the first clock of each frame
//
// Build option:
//   VGA_TIMING_CTRL_BORDER_EN  when defined, the outermost visible rows and
//                              columns are forced to white.
// ---------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic [11:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [11:0]      rgb,
  output logic             frame_start
);

  localparam int H_TOT     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA_START  = H_SYNC + H_BP;
  localparam int VA_START  = V_SYNC + V_BP;
  // The generator has one clock of latency, so requests run one column early
  localparam int REQ_START = HA_START - 1;

  // ---------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_h, cnt_v;

  vga_hv_counter #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_hv_counter (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .cnt_h   (cnt_h),
    .cnt_v   (cnt_v)
  );

  // ---------------------------------------------------------------------
  // Window decode on the current counter value
  // ---------------------------------------------------------------------
  logic h_req, h_act, v_act, active, in_req;

  always_comb begin
    h_req  = in_span(cnt_h, REQ_START, H_ACTIVE);
    h_act  = in_span(cnt_h, HA_START, H_ACTIVE);
    v_act  = in_span(cnt_v, VA_START, V_ACTIVE);
    active = h_act && v_act;
    in_req = h_req && v_act;
  end

  // Coordinates are combinational so the generator can register its colour
  // in the same clock that the request is presented.
  assign pix_x = in_req ? (cnt_h - CNT_W'(REQ_START)) : '0;
  assign pix_y = in_req ? (cnt_v - CNT_W'(VA_START))  : '0;

  // ---------------------------------------------------------------------
  // Colour path. pix_data arriving now belongs to column cnt_h-HA_START,
  // so gating it with 'active' of the current counter keeps rgb aligned
  // with de and the syncs.
  // ---------------------------------------------------------------------
  rgb444_t pix_gated;
  rgb444_t rgb_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_gate
      assign pix_gated[gi] = pix_data[gi] & active;
    end
  endgenerate

`ifdef VGA_TIMING_CTRL_BORDER_EN
  // Edge detection on the current counter is equivalent to comparing the
  // one-clock-delayed request coordinate against 0 and the last index.
  logic border;

  always_comb begin
    border = active &&
             ((cnt_h == CNT_W'(HA_START))                ||
              (cnt_h == CNT_W'(HA_START + H_ACTIVE - 1)) ||
              (cnt_v == CNT_W'(VA_START))                ||
              (cnt_v == CNT_W'(VA_START + V_ACTIVE - 1)));
  end

  assign rgb_sel = border ? WHITE : pix_gated;
`else
  assign rgb_sel = pix_gated;
`endif

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  vga_out_t out_reg, out_next;

  always_comb begin
    out_next             = VGA_OUT_IDLE;
    out_next.hsync       = !in_span(cnt_h, 0, H_SYNC);
    out_next.vsync       = !in_span(cnt_v, 0, V_SYNC);
    out_next.de          = active;
    out_next.frame_start = (cnt_h == '0) && (cnt_v == '0);
    out_next.rgb         = rgb_sel;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= VGA_OUT_IDLE;
    end else begin
      out_reg <= out_next;
    end
  end

  assign hsync       = out_reg.hsync;
  assign vsync       = out_reg.vsync;
  assign de          = out_reg.de;
  assign rgb         = out_reg.rgb;
  assign frame_start = out_reg.frame_start;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Generates 640x480@60 Hz VGA timing from the 25.175 MHz pixel clock and drives the display pins. Sits upstream and downstream of the pixel-colour generator: it issues the pixel coordinate one cycle ahead, takes back the registered 12-bit RGB444 colour, and emits hsync/vsync/rgb aligned on the same register stage. It also pulses once per frame so keyboard-driven logic can update on frame boundaries.

## Interface
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- vga_clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pix_data  in  12  colour from generator, registered there; valid one cycle after the matching pix_x/pix_y
- pix_x  out  10  requested column, combinational from counters
- pix_y  out  10  requested row, combinational from counters
- hsync  out  1  horizontal sync, active-low, registered
- vsync  out  1  vertical sync, active-low, registered
- de  out  1  display enable, registered
- rgb  out  12  pixel colour to DAC, registered
- frame_start  out  1  one-cycle pulse, first clock of each frame, registered

## Operation
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must be ≤ 1024; counters are 10 bits.
- cnt_h: 0..H_TOTAL-1, wraps to 0; cnt_v increments when cnt_h wraps, wraps 0 after V_TOTAL-1.
- Line order: sync [0,H_SYNC), back porch, active [HA0, HA0+H_ACTIVE) with HA0 = H_SYNC+H_BP (144), front porch. Vertical identical, VA0 = V_SYNC+V_BP (35).
- Request window: cnt_h in [HA0-1, HA0-1+H_ACTIVE) and cnt_v in [VA0, VA0+V_ACTIVE). Inside: pix_x = cnt_h-(HA0-1), pix_y = cnt_v-VA0. Outside: both 10'd0.
- Per clock, from the current counter value c: hsync <= ~(cnt_h < H_SYNC); vsync <= ~(cnt_v < V_SYNC); de <= active(c); rgb <= active(c) ? pix_data : 12'h000; frame_start <= (cnt_h==0 && cnt_v==0).
- pix_data sampled at counter c corresponds to column c-HA0, so rgb/de/hsync/vsync stay mutually aligned.
- No handshake; generator must have exactly one cycle of latency.

## Timing
- Reset: cnt_h=0, cnt_v=0, hsync=1, vsync=1, de=0, rgb=12'h000, frame_start=0.
- First clock after reset release: frame_start=1, hsync=0, vsync=0.
- pix_x → rgb latency: 2 clocks. Counter → registered outputs: 1 clock.
- Line period 800 clocks, hsync low 96; frame period 420000 clocks, vsync low 1600 clocks.
- Line wrap and frame wrap on same clock: cnt_h=0, cnt_v=0 simultaneously; no skipped or doubled line.
- Reset asserted mid-frame: all outputs to reset values immediately (async); restart from frame origin.

## Configuration
- VGA_TIMING_CTRL_BORDER_EN defined: during active pixels at column 0 or 639 or row 0 or 479, rgb <= 12'hFFF regardless of pix_data; requires a 1-clock-delayed column/row (or equivalent compare on c).
- Undefined: rgb is pix_data gated by active only; no extra logic.

## Structure
- Shared package vga_pkg: default timing constants (H_*/V_*, derived totals, HA0/VA0) and RGB444 colour constants (RED, GREEN, BLACK, WHITE, ...), shared with the pixel generator.
- One sub-module: vga_hv_counter (cnt_h/cnt_v pair with wrap); sync/request/output logic in top.

## Test plan
- Reset held, then released: outputs at reset values; next clock frame_start=1, hsync=0, vsync=0; frame_start next 420000 clocks later.
- Free run one line: hsync low exactly 96 clocks per 800; vsync low exactly 1600 clocks per 420000.
- Line 35: cnt_h=143 → pix_x=0,pix_y=0; cnt_h=782 → pix_x=639; cnt_h=783 → pix_x=0 (outside).
- Generator model with pix_data <= {2'b0,pix_x} one-cycle register: de high 640 clocks per active line, rgb equals column index each de cycle, rgb=0 whenever de=0.
- pix_data tied 12'hF00: rgb=12'h000 on lines 0..34 and 515..524, F00 on 480 active lines.
- Reset pulsed at line 200 col 400: outputs reset within same cycle; after release timing restarts at frame origin. With BORDER_EN: row 0 and column 639 read 12'hFFF.
